// File: rtl/dc2_4_buf.sv
// -----------------------------------------------------------------------------
// dc2_4_buf -- buffered 2-to-4 decoder
//
// Receives 2-bit line codes from an encoder-side producer over a valid/ready
// handshake, queues them in a DEPTH-entry FIFO and presents the head entry as a
// one-hot 4-bit word on a downstream valid/ready handshake. The queue lets the
// producer run ahead of a stalling consumer without losing events.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//
// Ports
//   clk    in   1              system clock, rising edge
//   rst    in   1              synchronous active-high reset
//   i      in   2              input code, selects output line 0..3
//   iv     in   1              input valid
//   irdy   out  1              input ready (FIFO not full)
//   o      out  4              one-hot decode of the head code, 0 when empty
//   ov     out  1              output valid (FIFO not empty)
//   ordy   in   1              downstream ready
//   cnt    out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module dc2_4_buf #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 i,
    input  logic                       iv,
    output logic                       irdy,
    output logic [3:0]                 o,
    output logic                       ov,
    input  logic                       ordy,
    output logic [$clog2(DEPTH):0]     cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Code storage; contents are deliberately left unreset.
    logic [1:0]    mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    logic          push;
    logic          pop;
    logic [1:0]    head;

    // Handshake flags come only from registered occupancy, so there is no
    // combinational path from iv/ordy to irdy/ov (no bypass, no fall-through).
    assign irdy = (cnt_reg != CW'(DEPTH));
    assign ov   = (cnt_reg != '0);
    assign cnt  = cnt_reg;

    assign push = iv && irdy;
    assign pop  = ov && ordy;

    always_comb begin
        cnt_next = cnt_reg;
        if (push && !pop) begin
            cnt_next = cnt_reg + CW'(1);
        end else if (pop && !push) begin
            cnt_next = cnt_reg - CW'(1);
        end
    end

    // Pointers wrap naturally at AW bits; full vs. empty is told apart by cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            cnt_reg <= cnt_next;
        end
    end

    // A push sampled together with reset is dropped, so the write is gated too.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_reg] <= i;
        end
    end

    // The head must be visible in the cycle right after it is written, so the
    // read is asynchronous off the registered read pointer.
    assign head = mem[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            assign o[gi] = ov && (head == 2'(gi));
        end
    endgenerate

endmodule
